// File: rtl/sbhw_buf.sv
// Store buffer: formats sb/sh/sw requests into lane-replicated word writes and
// drains them in order to data memory. Optional load forwarding under SB_FWD_EN.
module sbhw_buf #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_con,
  output logic        st_ade,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
`ifdef SB_FWD_EN
  input  logic [31:0] ld_addr,
  output logic        fwd_hit,
  output logic [31:0] fwd_data,
  output logic [3:0]  fwd_strb,
`endif
  output logic        sb_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [29:0]      q_addr [DEPTH];
  logic [31:0]      q_data [DEPTH];
  logic [3:0]       q_strb [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;

  logic        full, empty, push, pop;
  logic        is_sb, is_sh, is_sw;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // Lowest set control bit selects the access size.
  assign is_sb = st_con[0];
  assign is_sh = st_con[1] & ~st_con[0];
  assign is_sw = st_con[2] & ~|st_con[1:0];

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    wdata = '0;
    wstrb = '0;
    if (is_sb) begin
      wdata = {4{st_data[7:0]}};
      wstrb = 4'b0001 << st_addr[1:0];
    end else if (is_sh) begin
      wdata = {2{st_data[15:0]}};
      wstrb = st_addr[1] ? 4'b1100 : 4'b0011;
    end else if (is_sw) begin
      wdata = st_data;
      wstrb = 4'b1111;
    end
  end

  assign st_ade   = st_valid & ((is_sh & st_addr[0]) | (is_sw & (st_addr[1:0] != 2'b00)));
  assign st_ready = ~full & ~rst;
  assign push     = st_valid & st_ready & ~st_ade & (st_con != 3'b000);

  assign mem_req  = ~empty & ~rst;
  assign pop      = mem_req & mem_ack;
  assign sb_empty = empty | rst;

  assign mem_addr  = mem_req ? {q_addr[head], 2'b00} : 32'h0;
  assign mem_wdata = mem_req ? q_data[head] : 32'h0;
  assign mem_wstrb = mem_req ? q_strb[head] : 4'h0;

  // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: entry storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail] <= st_addr[31:2];
      q_data[tail] <= wdata;
      q_strb[tail] <= wstrb;
    end
  end

`ifdef SB_FWD_EN
  logic [PTR_W-1:0] fwd_idx;

  // Walk oldest to youngest so younger matches overwrite older lanes.
  always_comb begin
    fwd_data = '0;
    fwd_strb = '0;
    fwd_idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      fwd_idx = head + PTR_W'(k);
      if ((CNT_W'(k) < count) && (q_addr[fwd_idx] == ld_addr[31:2])) begin
        fwd_strb = fwd_strb | q_strb[fwd_idx];
        for (int b = 0; b < 4; b++) begin
          if (q_strb[fwd_idx][b]) fwd_data[8*b +: 8] = q_data[fwd_idx][8*b +: 8];
        end
      end
    end
  end

  assign fwd_hit = |fwd_strb;
`endif

endmodule

// File: tb/tb_sbhw_buf.sv
// Scoreboard bench for sbhw_buf: expected writes are queued at issue and checked
// as the buffer drains. Forwarding checks are compiled in with SB_FWD_EN.
module tb_sbhw_buf;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_con = '0;
  logic        st_ade;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack = 1'b0;
  logic        sb_empty;
`ifdef SB_FWD_EN
  logic [31:0] ld_addr = '0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_strb;
`endif

  int   total = 0;
  int   bad = 0;
  int   pop_cnt = 0;
  exp_t sb_q[$];
  exp_t got;
  exp_t want;

  sbhw_buf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_data(st_data), .st_con(st_con), .st_ade(st_ade),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
`ifdef SB_FWD_EN
    .ld_addr(ld_addr), .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_strb(fwd_strb),
`endif
    .sb_empty(sb_empty)
  );

  always #5 clk = ~clk;

  // Reference formatting: lowest set control bit picks the size.
  function automatic exp_t fmt(input logic [2:0] con, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = {a[31:2], 2'b00};
    e.data = 32'h0;
    e.strb = 4'h0;
    if (con[0]) begin
      e.data = {d[7:0], d[7:0], d[7:0], d[7:0]};
      case (a[1:0])
        2'd0: e.strb = 4'b0001;
        2'd1: e.strb = 4'b0010;
        2'd2: e.strb = 4'b0100;
        default: e.strb = 4'b1000;
      endcase
    end else if (con[1]) begin
      e.data = {d[15:0], d[15:0]};
      e.strb = a[1] ? 4'b1100 : 4'b0011;
    end else if (con[2]) begin
      e.data = d;
      e.strb = 4'b1111;
    end
    return e;
  endfunction

  // Every accepted write is compared against the scoreboard head.
  always @(negedge clk) begin
    if (mem_req && mem_ack) begin
      pop_cnt++;
      total++;
      got = '{mem_addr, mem_wdata, mem_wstrb};
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL drain_unexpected: got addr=%h data=%h strb=%b, required no write", mem_addr, mem_wdata, mem_wstrb);
      end else begin
        want = sb_q.pop_front();
        if (got !== want) begin
          bad++;
          $display("FAIL drain_entry: got addr=%h data=%h strb=%b, required addr=%h data=%h strb=%b",
                   got.addr, got.data, got.strb, want.addr, want.data, want.strb);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_store(input logic [2:0] con, input logic [31:0] a, input logic [31:0] d);
    st_valid = 1'b1;
    st_con   = con;
    st_addr  = a;
    st_data  = d;
  endtask

  task automatic clr_store();
    st_valid = 1'b0;
    st_con   = 3'b000;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty, st_ready, mem_wstrb} !== 7'b0100000) begin
      bad++;
      $display("FAIL reset_hold: got req=%b empty=%b ready=%b strb=%b, required 0 1 0 0000",
               mem_req, sb_empty, st_ready, mem_wstrb);
    end
    tick();
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty, st_ready, mem_addr} !== {3'b011, 32'h0}) begin
      bad++;
      $display("FAIL reset_release: got req=%b empty=%b ready=%b addr=%h, required 0 1 1 0",
               mem_req, sb_empty, st_ready, mem_addr);
    end
  endtask

  task automatic test_sb();
    tick();
    set_store(3'b001, 32'h0000_1003, 32'h0000_00A5);
    @(negedge clk);
    sb_q.push_back(fmt(3'b001, 32'h0000_1003, 32'h0000_00A5));
    total++;
    if (st_ade !== 1'b0) begin
      bad++;
      $display("FAIL sb_ade: got %b, required 0", st_ade);
    end
    tick();
    clr_store();
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty, mem_addr, mem_wdata, mem_wstrb} !== {2'b10, 32'h0000_1000, 32'hA5A5_A5A5, 4'b1000}) begin
      bad++;
      $display("FAIL sb_request: got req=%b empty=%b addr=%h data=%h strb=%b, required 1 0 00001000 a5a5a5a5 1000",
               mem_req, sb_empty, mem_addr, mem_wdata, mem_wstrb);
    end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty} !== 2'b01) begin
      bad++;
      $display("FAIL sb_drained: got req=%b empty=%b, required 0 1", mem_req, sb_empty);
    end
  endtask

  task automatic test_sh_ade();
    tick();
    set_store(3'b010, 32'h0000_2002, 32'h1234_BEEF);
    @(negedge clk);
    sb_q.push_back(fmt(3'b010, 32'h0000_2002, 32'h1234_BEEF));
    tick();
    set_store(3'b100, 32'h0000_3001, 32'h0000_0055);
    mem_ack = 1'b1;
    @(negedge clk);
    total++;
    if (st_ade !== 1'b1) begin
      bad++;
      $display("FAIL sw_misaligned_ade: got %b, required 1", st_ade);
    end
    total++;
    if ({mem_addr, mem_wdata, mem_wstrb} !== {32'h0000_2000, 32'hBEEF_BEEF, 4'b1100}) begin
      bad++;
      $display("FAIL sh_lanes: got addr=%h data=%h strb=%b, required 00002000 beefbeef 1100",
               mem_addr, mem_wdata, mem_wstrb);
    end
    tick();
    mem_ack = 1'b0;
    set_store(3'b110, 32'h0000_2001, 32'h0);
    @(negedge clk);
    total++;
    if ({st_ade, sb_empty} !== 2'b11) begin
      bad++;
      $display("FAIL sh_misaligned_ade: got ade=%b empty=%b, required 1 1", st_ade, sb_empty);
    end
    tick();
    set_store(3'b000, 32'h0000_2000, 32'h77);
    @(negedge clk);
    total++;
    if ({st_ade, sb_empty, st_ready} !== 3'b011) begin
      bad++;
      $display("FAIL invalid_con: got ade=%b empty=%b ready=%b, required 0 1 1", st_ade, sb_empty, st_ready);
    end
    tick();
    clr_store();
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty} !== 2'b01) begin
      bad++;
      $display("FAIL nothing_enqueued: got req=%b empty=%b, required 0 1", mem_req, sb_empty);
    end
  endtask

  task automatic test_full();
    int p0;
    for (int i = 0; i < 4; i++) begin
      tick();
      set_store(3'b100, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      @(negedge clk);
      sb_q.push_back(fmt(3'b100, 32'h100 + 32'(4 * i), 32'hA000_0000 + 32'(i)));
    end
    tick();
    clr_store();
    @(negedge clk);
    total++;
    if ({st_ready, mem_addr} !== {1'b0, 32'h100}) begin
      bad++;
      $display("FAIL full_ready: got ready=%b addr=%h, required 0 00000100", st_ready, mem_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if ({mem_req, mem_addr, mem_wdata} !== {1'b1, 32'h100, 32'hA000_0000}) begin
      bad++;
      $display("FAIL head_stable: got req=%b addr=%h data=%h, required 1 00000100 a0000000", mem_req, mem_addr, mem_wdata);
    end
    tick();
    mem_ack = 1'b1;
    @(negedge clk);
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_after_pop: got %b, required 1", st_ready);
    end
    tick();
    set_store(3'b100, 32'h110, 32'hA000_0004);
    @(negedge clk);
    sb_q.push_back(fmt(3'b100, 32'h110, 32'hA000_0004));
    tick();
    set_store(3'b100, 32'h1F0, 32'hDEAD_DEAD);
    mem_ack = 1'b1;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_no_bypass: got ready=%b, required 0", st_ready);
    end
    tick();
    clr_store();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL pop_only_count3: got ready=%b, required 1", st_ready);
    end
    tick();
    set_store(3'b100, 32'h114, 32'hA000_0005);
    mem_ack = 1'b1;
    @(negedge clk);
    sb_q.push_back(fmt(3'b100, 32'h114, 32'hA000_0005));
    tick();
    clr_store();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (st_ready !== 1'b1) begin
      bad++;
      $display("FAIL push_pop_count3: got ready=%b, required 1", st_ready);
    end
    p0 = pop_cnt;
    tick();
    mem_ack = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (sb_empty) break;
      tick();
    end
    mem_ack = 1'b0;
    total++;
    if ({sb_empty, 32'(pop_cnt - p0), 32'(sb_q.size())} !== {1'b1, 32'd3, 32'd0}) begin
      bad++;
      $display("FAIL full_drain: got empty=%b pops=%0d left=%0d, required 1 3 0", sb_empty, pop_cnt - p0, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0]  cons [3] = '{3'b111, 3'b110, 3'b100};
    logic [31:0] adrs [3] = '{32'h3002, 32'h3006, 32'h3008};
    logic [31:0] dats [3] = '{32'h1234_5678, 32'hCAFE_1234, 32'h0BAD_F00D};
    int p0;
    for (int i = 0; i < 3; i++) begin
      tick();
      set_store(cons[i], adrs[i], dats[i]);
      @(negedge clk);
      sb_q.push_back(fmt(cons[i], adrs[i], dats[i]));
    end
    tick();
    clr_store();
    p0 = pop_cnt;
    mem_ack = 1'b1;
    repeat (3) tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if ({sb_empty, 32'(pop_cnt - p0)} !== {1'b1, 32'd3}) begin
      bad++;
      $display("FAIL back_to_back: got empty=%b pops=%0d, required 1 3", sb_empty, pop_cnt - p0);
    end
  endtask

  task automatic test_reset_pending();
    for (int i = 0; i < 2; i++) begin
      tick();
      set_store(3'b100, 32'h500 + 32'(4 * i), 32'h5500_0000 + 32'(i));
      @(negedge clk);
      sb_q.push_back(fmt(3'b100, 32'h500 + 32'(4 * i), 32'h5500_0000 + 32'(i)));
    end
    tick();
    clr_store();
    rst = 1'b1;
    mem_ack = 1'b1;
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty, st_ready} !== 3'b010) begin
      bad++;
      $display("FAIL reset_pending: got req=%b empty=%b ready=%b, required 0 1 0", mem_req, sb_empty, st_ready);
    end
    tick();
    rst = 1'b0;
    mem_ack = 1'b0;
    sb_q.delete();
    @(negedge clk);
    total++;
    if ({mem_req, sb_empty, st_ready} !== 3'b011) begin
      bad++;
      $display("FAIL reset_discard: got req=%b empty=%b ready=%b, required 0 1 1", mem_req, sb_empty, st_ready);
    end
  endtask

`ifdef SB_FWD_EN
  task automatic test_fwd();
    tick();
    set_store(3'b100, 32'h40, 32'h1122_3344);
    @(negedge clk);
    sb_q.push_back(fmt(3'b100, 32'h40, 32'h1122_3344));
    tick();
    set_store(3'b001, 32'h41, 32'h0000_00FF);
    @(negedge clk);
    sb_q.push_back(fmt(3'b001, 32'h41, 32'h0000_00FF));
    tick();
    clr_store();
    ld_addr = 32'h40;
    @(negedge clk);
    total++;
    if ({fwd_hit, fwd_strb, fwd_data} !== {1'b1, 4'b1111, 32'h1122_FF44}) begin
      bad++;
      $display("FAIL fwd_hit: got hit=%b strb=%b data=%h, required 1 1111 1122ff44", fwd_hit, fwd_strb, fwd_data);
    end
    tick();
    ld_addr = 32'h44;
    @(negedge clk);
    total++;
    if ({fwd_hit, fwd_strb, fwd_data} !== {1'b0, 4'b0000, 32'h0}) begin
      bad++;
      $display("FAIL fwd_miss: got hit=%b strb=%b data=%h, required 0 0000 0", fwd_hit, fwd_strb, fwd_data);
    end
    tick();
    mem_ack = 1'b1;
    tick();
    tick();
    mem_ack = 1'b0;
    @(negedge clk);
    total++;
    if (sb_empty !== 1'b1) begin
      bad++;
      $display("FAIL fwd_drain: got empty=%b, required 1", sb_empty);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_sb();
    test_sh_ade();
    test_full();
    test_back_to_back();
    test_reset_pending();
`ifdef SB_FWD_EN
    test_fwd();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
